// File: rtl/stream_median3x3.sv
// stream_median3x3: streaming 3x3 median filter over a raster-order frame.
//
// A frame starts with a one-cycle Start_sig in idle. Pixels are accepted while
// in_ready is high (RUN) and pushed through two line buffers into a 3x3 window.
// Once the last pixel is in, COLS+1 zero-valued flush advances drain the window.
// Every window advance from the (COLS+2)th onwards produces one output, which
// leaves a 3-stage compare-exchange median network three cycles later.
// Border pixels pass their original centre value unchanged.
//
// Optional feature, macro MEDFILT_ADAPTIVE_EN: when defined, an interior pixel is
// replaced by the median only if its centre is 0 or all-ones (salt/pepper noise).
//
// Parameters:
//   DATA_W  pixel width in bits
//   COLS    pixels per row (4..1024)
//   ROWS    rows per frame (3..1024)
// Ports:
//   CLK        clock, rising edge
//   RST        asynchronous active-high reset
//   Start_sig  one-cycle frame start request (ignored outside idle)
//   in_valid   input pixel valid
//   in_ready   high only while running; accept = in_valid & in_ready
//   in_data    input pixel, raster order
//   out_valid  one-cycle strobe per filtered pixel
//   out_data   filtered pixel
//   Done_sig   pulse coincident with the last output pixel of a frame

module stream_median3x3 #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned COLS   = 512,
    parameter int unsigned ROWS   = 512
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start_sig,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              Done_sig
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);

    localparam logic [CW-1:0] ColMax    = CW'(COLS - 1);
    localparam logic [RW-1:0] RowMax    = RW'(ROWS - 1);
    // Advances needed before the first window centre holds pixel 0.
    localparam logic [CW:0]   FillSat   = (CW + 1)'(COLS + 1);
    localparam logic [CW:0]   FlushLast = (CW + 1)'(COLS);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e            state_q;
    logic [CW-1:0]     col_q;      // column of the advancing pixel (runs through flush)
    logic [RW-1:0]     row_q;      // row of the accepted pixel
    logic [CW:0]       flush_q;
    logic [CW:0]       fill_q;     // saturating advance count
    logic [CW-1:0]     kc_q;       // column of the next output centre
    logic [RW-1:0]     kr_q;       // row of the next output centre

    logic [DATA_W-1:0] lb0_q [COLS];  // previous row
    logic [DATA_W-1:0] lb1_q [COLS];  // row before that
    logic [DATA_W-1:0] win_q [3][3];  // [row][col], col 2 is newest

    logic              win_vld_q, win_brd_q, win_last_q;

    logic [DATA_W-1:0] s1_lo_q [3];
    logic [DATA_W-1:0] s1_md_q [3];
    logic [DATA_W-1:0] s1_hi_q [3];
    logic [DATA_W-1:0] s1_ctr_q;
    logic              s1_vld_q, s1_brd_q, s1_last_q;

    logic [DATA_W-1:0] s2_a_q, s2_b_q, s2_c_q;
    logic [DATA_W-1:0] s2_ctr_q;
    logic              s2_vld_q, s2_brd_q, s2_last_q;

    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q, done_q;

    logic              accept, advance, emit, s2_keep;
    logic [DATA_W-1:0] shift_in, tap1, tap2;
    logic [DATA_W-1:0] row_lo [3];
    logic [DATA_W-1:0] row_md [3];
    logic [DATA_W-1:0] row_hi [3];
    logic [DATA_W-1:0] col_max, col_med, col_min, med;

    // Ascending sort of three values, returned as {hi, mid, lo}.
    function automatic logic [3*DATA_W-1:0] sort3(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b,
                                                  input logic [DATA_W-1:0] c);
        logic [DATA_W-1:0] x, y, z, t;
        x = a;
        y = b;
        z = c;
        if (x > y) begin t = x; x = y; y = t; end
        if (y > z) begin t = y; y = z; z = t; end
        if (x > y) begin t = x; x = y; y = t; end
        return {z, y, x};
    endfunction

    assign in_ready = (state_q == StRun);
    assign accept   = in_valid && (state_q == StRun);
    assign advance  = accept || (state_q == StFlush);
    assign emit     = advance && (fill_q == FillSat);
    assign shift_in = accept ? in_data : '0;
    assign tap1     = lb0_q[col_q];
    assign tap2     = lb1_q[col_q];

    // FSM, counters and window.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            flush_q    <= '0;
            fill_q     <= '0;
            kc_q       <= '0;
            kr_q       <= '0;
            win_vld_q  <= 1'b0;
            win_brd_q  <= 1'b0;
            win_last_q <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            win_vld_q  <= emit;
            win_brd_q  <= (kr_q == '0) || (kr_q == RowMax) || (kc_q == '0) || (kc_q == ColMax);
            win_last_q <= (kr_q == RowMax) && (kc_q == ColMax);

            if (advance) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= tap2;
                win_q[1][2] <= tap1;
                win_q[2][2] <= shift_in;
                col_q       <= (col_q == ColMax) ? '0 : col_q + 1'b1;
                if (fill_q != FillSat) begin
                    fill_q <= fill_q + 1'b1;
                end
            end

            if (emit) begin
                if (kc_q == ColMax) begin
                    kc_q <= '0;
                    kr_q <= kr_q + 1'b1;
                end else begin
                    kc_q <= kc_q + 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (Start_sig) begin
                        state_q <= StRun;
                        col_q   <= '0;
                        row_q   <= '0;
                        flush_q <= '0;
                        fill_q  <= '0;
                        kc_q    <= '0;
                        kr_q    <= '0;
                    end
                end
                StRun: begin
                    if (accept && (col_q == ColMax)) begin
                        if (row_q == RowMax) begin
                            state_q <= StFlush;
                            flush_q <= '0;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    flush_q <= flush_q + 1'b1;
                    if (flush_q == FlushLast) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Line buffers carry no reset; stale contents only reach border outputs.
    always_ff @(posedge CLK) begin
        if (advance) begin
            lb0_q[col_q] <= shift_in;
            lb1_q[col_q] <= tap1;
        end
    end

    // Compare-exchange network: row sort, column sort, diagonal median.
    always_comb begin
        logic [3*DATA_W-1:0] srt;
        srt = '0;
        for (int i = 0; i < 3; i++) begin
            srt       = sort3(win_q[i][0], win_q[i][1], win_q[i][2]);
            row_lo[i] = srt[DATA_W-1:0];
            row_md[i] = srt[2*DATA_W-1:DATA_W];
            row_hi[i] = srt[3*DATA_W-1:2*DATA_W];
        end
        srt     = sort3(s1_lo_q[0], s1_lo_q[1], s1_lo_q[2]);
        col_max = srt[3*DATA_W-1:2*DATA_W];
        srt     = sort3(s1_md_q[0], s1_md_q[1], s1_md_q[2]);
        col_med = srt[2*DATA_W-1:DATA_W];
        srt     = sort3(s1_hi_q[0], s1_hi_q[1], s1_hi_q[2]);
        col_min = srt[DATA_W-1:0];
        srt     = sort3(s2_a_q, s2_b_q, s2_c_q);
        med     = srt[2*DATA_W-1:DATA_W];
    end

`ifdef MEDFILT_ADAPTIVE_EN
    assign s2_keep = s2_brd_q || !((s2_ctr_q == '0) || (s2_ctr_q == '1));
`else
    assign s2_keep = s2_brd_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < 3; i++) begin
                s1_lo_q[i] <= '0;
                s1_md_q[i] <= '0;
                s1_hi_q[i] <= '0;
            end
            s1_ctr_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_brd_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_a_q      <= '0;
            s2_b_q      <= '0;
            s2_c_q      <= '0;
            s2_ctr_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_brd_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                s1_lo_q[i] <= row_lo[i];
                s1_md_q[i] <= row_md[i];
                s1_hi_q[i] <= row_hi[i];
            end
            s1_ctr_q    <= win_q[1][1];
            s1_vld_q    <= win_vld_q;
            s1_brd_q    <= win_brd_q;
            s1_last_q   <= win_last_q;

            s2_a_q      <= col_max;
            s2_b_q      <= col_med;
            s2_c_q      <= col_min;
            s2_ctr_q    <= s1_ctr_q;
            s2_vld_q    <= s1_vld_q;
            s2_brd_q    <= s1_brd_q;
            s2_last_q   <= s1_last_q;

            out_valid_q <= s2_vld_q;
            done_q      <= s2_vld_q && s2_last_q;
            if (s2_vld_q) begin
                out_data_q <= s2_keep ? s2_ctr_q : med;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign Done_sig  = done_q;

endmodule

// File: tb/tb_stream_median3x3.sv
// Scoreboard bench for stream_median3x3 on a 4x4 frame. The driver pushes the
// hand-computed expected frame when it starts a frame; an independent monitor
// pops and compares on every out_valid.

module tb_stream_median3x3;

    localparam int NC   = 4;
    localparam int NR   = 4;
    localparam int NPIX = NC * NR;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Start_sig = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       Done_sig;

    stream_median3x3 #(
        .DATA_W (8),
        .COLS   (NC),
        .ROWS   (NR)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Start_sig (Start_sig),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .Done_sig  (Done_sig)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic [7:0] idx;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   first_out_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] pix(input logic [127:0] f, input int i);
        return f[127-8*i -: 8];
    endfunction

    // Monitor
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got data %0h with empty scoreboard", out_data);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("out_data[%0d]", e.idx), 32'(out_data), 32'(e.d));
                    check($sformatf("done[%0d]", e.idx), 32'(Done_sig), 32'(e.last));
                    if (e.idx == 8'd0) first_out_cyc = cyc;
                end
            end else if (Done_sig) begin
                total++;
                bad++;
                $display("FAIL stray_done: got 1 want 0 without out_valid");
            end
        end
    end

    task automatic run_frame(input string nm, input logic [127:0] fin, input logic [127:0] fexp,
                             input bit gappy, input bit chk_lat, input int abort_at);
        int  i;
        int  guard;
        int  acc5;
        int  hits;
        bit  acc;
        @(negedge CLK);
        check({nm, ":idle_ready"}, 32'(in_ready), 32'd0);
        Start_sig = 1'b1;
        for (int k = 0; k < NPIX; k++) begin
            sb.push_back('{d: pix(fexp, k), last: (k == NPIX - 1), idx: 8'(k)});
        end
        @(negedge CLK);
        Start_sig = 1'b0;
        check({nm, ":run_ready"}, 32'(in_ready), 32'd1);
        i     = 0;
        guard = 0;
        acc5  = 0;
        while (i < NPIX && guard < 1000) begin
            guard++;
            in_valid  = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data   = in_valid ? pix(fin, i) : 8'($urandom);
            Start_sig = gappy && (i == 8);  // must be ignored while running
            acc       = in_valid && in_ready;
            if (acc && i == 5) acc5 = cyc + 1;
            @(posedge CLK);
            if (acc) i++;
            if (acc && abort_at >= 0 && i == abort_at + 1) begin
                #2 RST = 1'b1;
                #1;
                check({nm, ":rst_out_data"}, 32'(out_data), 32'd0);
                check({nm, ":rst_out_valid"}, 32'(out_valid), 32'd0);
                check({nm, ":rst_in_ready"}, 32'(in_ready), 32'd0);
                check({nm, ":rst_done"}, 32'(Done_sig), 32'd0);
                sb.delete();
                in_valid  = 1'b0;
                Start_sig = 1'b0;
                repeat (3) @(negedge CLK);
                RST      = 1'b0;
                in_valid = 1'b1;
                hits     = 0;
                repeat (20) begin
                    @(negedge CLK);
                    if (in_ready) hits++;
                end
                in_valid = 1'b0;
                check({nm, ":post_rst_ready"}, 32'(hits), 32'd0);
                return;
            end
            @(negedge CLK);
        end
        Start_sig = 1'b0;
        in_valid  = 1'b0;
        if (guard >= 1000) begin
            total++;
            bad++;
            $display("FAIL %s:accept_timeout: got %0d pixels want %0d", nm, i, NPIX);
        end
        hits = 0;
        repeat (NC + 3) begin
            if (in_ready) hits++;
            @(negedge CLK);
        end
        check({nm, ":flush_ready"}, 32'(hits), 32'd0);
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        check({nm, ":drain_left"}, 32'(sb.size()), 32'd0);
        if (chk_lat) check({nm, ":latency"}, 32'(first_out_cyc - acc5), 32'd3);
    endtask

    logic [127:0] f1, f2i, f2e, f3i, f3e, f4i, f4e, f5i, f5e;

    initial begin
        f1  = {16{8'h40}};
        f2i = 128'h10101010_10FF1010_10101010_10101010;
        f2e = {16{8'h10}};
        f3i = 128'h10203040_50056070_80900AA0_B0C0D0E0;
`ifdef MEDFILT_ADAPTIVE_EN
        f3e = f3i;
`else
        f3e = 128'h10203040_50304070_808090A0_B0C0D0E0;
`endif
        f4i = 128'h00000011_0080FF22_FFFFFF33_44556677;
        f4e = 128'h00000011_00803322_FF807733_44556677;
        f5i = 128'h00000011_0000FF22_FFFFFF33_44556677;
        f5e = 128'h00000011_00002222_FF666633_44556677;

        #12;
        check("reset:in_ready", 32'(in_ready), 32'd0);
        check("reset:out_valid", 32'(out_valid), 32'd0);
        check("reset:out_data", 32'(out_data), 32'd0);
        check("reset:done", 32'(Done_sig), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        run_frame("const40", f1, f1, 1'b0, 1'b1, -1);
        run_frame("salt", f2i, f2e, 1'b0, 1'b0, -1);
        run_frame("ramp", f3i, f3e, 1'b0, 1'b1, -1);
        run_frame("ramp_gap", f3i, f3e, 1'b1, 1'b0, -1);
        run_frame("abort", f3i, f3e, 1'b0, 1'b0, 7);
        run_frame("after_rst", f3i, f3e, 1'b0, 1'b1, -1);
        run_frame("sp80", f4i, f4e, 1'b0, 1'b0, -1);
        run_frame("sp00", f5i, f5e, 1'b1, 1'b0, -1);

        repeat (5) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
